sprite_line_buffer: RTL and testbench



---
 rtl/sprite_line_buffer.sv | 133 +++++++++++++
 tb/tb_sprite_line_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: the sprite engine draws the next line into one bank
// while the other bank is scanned out and cleared, with first-drawn-wins priority.
module sprite_line_buffer #(
  parameter int unsigned AW     = 9,
  parameter int unsigned DW     = 8,
  parameter int unsigned VIS_W  = 320,
  parameter logic [3:0]  TRANSP = 4'hF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_pix,
  input  logic [8:0]    hc,
  input  logic          hbl,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_x,
  input  logic [DW-1:0] wr_pix,
  output logic          line_start,
  output logic [DW-1:0] rd_pix
);

  localparam logic [DW-1:0] TV       = {{(DW-4){1'b0}}, TRANSP};
  localparam logic [AW-1:0] LAST_CLR = AW'(VIS_W - 1);
  localparam logic [AW:0]   VIS_LIM  = (AW+1)'(VIS_W);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic          sel;
  logic          hbl_d;

  logic [DW-1:0] mem [2][2**AW];

  logic          s1_valid, s1_bank;
  logic [AW-1:0] s1_x;
  logic [DW-1:0] s1_pix;
  logic          s2_valid, s2_bank;
  logic [AW-1:0] s2_x;
  logic [DW-1:0] s2_pix;
  logic [3:0]    s2_old_pen;

  logic [3:0]    s1_old_pen;
  logic [AW-1:0] rd_addr;
  logic          keep, swap, rd_en, s2_we;

  always_comb begin
    rd_addr = AW'(hc);
    keep    = wr_valid && wr_ready && ({1'b0, wr_x} < VIS_LIM) && (wr_pix[3:0] != TRANSP);
    swap    = (state == RUN) && clk_pix && hbl && !hbl_d;
    rd_en   = (state == RUN) && clk_pix && !hbl;
    s2_we   = s2_valid && (s2_old_pen == TRANSP);
    // S2 lands at the end of this clk; S1 must see it or back-to-back hits would both win.
    s1_old_pen = mem[s1_bank][s1_x][3:0];
    if (s2_we && (s2_bank == s1_bank) && (s2_x == s1_x))
      s1_old_pen = s2_pix[3:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      sel        <= 1'b0;
      hbl_d      <= 1'b0;
      line_start <= 1'b0;
      wr_ready   <= 1'b0;
      rd_pix     <= TV;
      s1_valid   <= 1'b0;
      s1_bank    <= 1'b0;
      s1_x       <= '0;
      s1_pix     <= '0;
      s2_valid   <= 1'b0;
      s2_bank    <= 1'b0;
      s2_x       <= '0;
      s2_pix     <= '0;
      s2_old_pen <= '0;
    end else begin
      line_start <= swap;
      if (clk_pix)
        hbl_d <= hbl;

      s1_valid <= keep;
      if (keep) begin
        s1_x    <= wr_x;
        s1_pix  <= wr_pix;
        s1_bank <= ~sel;
      end
      s2_valid   <= s1_valid;
      s2_x       <= s1_x;
      s2_pix     <= s1_pix;
      s2_bank    <= s1_bank;
      s2_old_pen <= s1_old_pen;

      if (rd_en)
        rd_pix <= mem[sel][rd_addr];
      else if (clk_pix && hbl)
        rd_pix <= TV;

      case (state)
        CLEAR: begin
          wr_ready <= 1'b0;
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_CLR) begin
            state    <= RUN;
            wr_ready <= 1'b1;
          end
        end
        RUN: begin
          wr_ready <= !swap;
          if (swap)
            sel <= ~sel;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Bank storage is deliberately not reset; CLEAR initialises the visible span.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[0][clr_addr] <= TV;
        mem[1][clr_addr] <= TV;
      end else begin
        if (rd_en)
          mem[sel][rd_addr] <= TV;
        if (s2_we)
          mem[s2_bank][s2_x] <= s2_pix;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: clear timing, draw/scan/clear-on-read,
// priority with forwarding, dropped writes, swap pulse and reset mid-burst.
module tb_sprite_line_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_pix = 1'b0;
  logic [8:0] hc = '0;
  logic       hbl = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [8:0] wr_x = '0;
  logic [7:0] wr_pix = '0;
  logic       line_start;
  logic [7:0] rd_pix;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] line_exp [320];

  sprite_line_buffer #(.AW(9), .DW(8), .VIS_W(320), .TRANSP(4'hF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_pix    (clk_pix),
    .hc         (hc),
    .hbl        (hbl),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_pix     (wr_pix),
    .line_start (line_start),
    .rd_pix     (rd_pix)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic reset_and_clear();
    int cnt;
    reset_n = 1'b0;
    clk_pix = 1'b0;
    hbl     = 1'b0;
    hc      = '0;
    repeat (2) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("reset rd_pix", rd_pix, 8'h0F);
    check("reset line_start", line_start, 1'b0);
    check("reset wr_ready", wr_ready, 1'b0);
    reset_n = 1'b1;
    cnt = 0;
    while (wr_ready !== 1'b1 && cnt < 400) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("clear length", cnt, 320);
  endtask

  task automatic do_write(input logic [8:0] x, input logic [7:0] p);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_pix   = p;
    check($sformatf("wr_ready x=%0d", x), wr_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic end_writes();
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic exp_blank();
    for (int i = 0; i < 320; i++) line_exp[i] = 8'h0F;
  endtask

  // One line: 400 pixels, each a clk_pix clk followed by an idle clk.
  task automatic scan_line(input string name);
    logic [7:0] exp_rd;
    for (int h = 0; h < 400; h++) begin
      clk_pix = 1'b1;
      hc      = h[8:0];
      hbl     = (h >= 320);
      @(posedge clk);
      #1;
      exp_rd = (h < 320) ? line_exp[h] : 8'h0F;
      check($sformatf("%s rd_pix hc=%0d", name, h), rd_pix, exp_rd);
      check($sformatf("%s line_start hc=%0d", name, h), line_start, (h == 320));
      check($sformatf("%s wr_ready hc=%0d", name, h), wr_ready, (h != 320));
      clk_pix = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("%s rd_pix hold hc=%0d", name, h), rd_pix, exp_rd);
      check($sformatf("%s line_start idle hc=%0d", name, h), line_start, 1'b0);
    end
  endtask

  initial begin
    reset_and_clear();

    do_write(9'd10, 8'h23);
    do_write(9'd5, 8'h31);
    do_write(9'd5, 8'h42);
    do_write(9'd7, 8'h5F);
    do_write(9'd320, 8'h11);
    end_writes();

    exp_blank();
    scan_line("lineA");

    exp_blank();
    line_exp[10] = 8'h23;
    line_exp[5]  = 8'h31;
    scan_line("lineB");

    do_write(9'd0, 8'h81);
    do_write(9'd319, 8'h7A);
    end_writes();

    exp_blank();
    scan_line("lineC");

    exp_blank();
    line_exp[0]   = 8'h81;
    line_exp[319] = 8'h7A;
    scan_line("lineD");

    do_write(9'd20, 8'h6C);
    do_write(9'd21, 8'h6C);
    do_write(9'd22, 8'h6C);
    do_write(9'd23, 8'h6C);
    wr_x = 9'd24;
    reset_and_clear();

    exp_blank();
    scan_line("postrst1");
    scan_line("postrst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
